// File: rtl/seq_unsigned_divider.sv
// Multi-cycle unsigned divider. Restoring shift/subtract, one quotient bit per enabled clock.
// Latency: WIDTH+1 cycles from start to done. Divide-by-zero completes in 1 cycle.
// Backpressure: start is ignored while busy=1. en=0 freezes every register, including done.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset that overrides en and start
//   en              clock enable for all state
//   start           request, accepted on an enabled edge while idle
//   dividend        numerator, sampled only on the accepting edge
//   divisor         denominator, sampled only on the accepting edge
//   busy            high while a division is in progress
//   done            one-enabled-cycle pulse marking a new result
//   quotient        last completed result, held between completions
//   remainder       last completed result, held between completions
//   div_by_zero     last completed operation had divisor==0
module seq_unsigned_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder
    logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend bits shift out at the MSB, quotient bits shift in at the LSB
    logic [WIDTH-1:0] dsr_q, dsr_d;     // latched divisor
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_d;
    logic             dz_d;
    logic [WIDTH-1:0] quotient_d;
    logic [WIDTH-1:0] remainder_d;

    // One restoring step
    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_dvd;

    // The partial remainder is always below the divisor, so the shifted value is
    // below 2*divisor and needs WIDTH+1 bits. The compare is made at that width.
    // When it fits, the true difference is below the divisor. That lets the low
    // WIDTH bits of the subtraction stand alone.
    always_comb begin
        shifted  = {rem_q, dvd_q[WIDTH-1]};
        fits     = (shifted >= {1'b0, dsr_q});
        step_rem = fits ? (shifted[WIDTH-1:0] - dsr_q) : shifted[WIDTH-1:0];
        step_dvd = {dvd_q[WIDTH-2:0], fits};
    end

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        dvd_d       = dvd_q;
        dsr_d       = dsr_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        quotient_d  = quotient;
        remainder_d = remainder;
        dz_d        = div_by_zero;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        // No iteration. Report the saturated result immediately.
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dz_d        = 1'b1;
                        done_d      = 1'b1;
                    end else begin
                        dvd_d   = dividend;
                        dsr_d   = divisor;
                        rem_d   = '0;
                        cnt_d   = '0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                rem_d = step_rem;
                dvd_d = step_dvd;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    quotient_d  = step_dvd;
                    remainder_d = step_rem;
                    dz_d        = 1'b0;
                    done_d      = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            cnt_q       <= '0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (en) begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            dvd_q       <= dvd_d;
            dsr_q       <= dsr_d;
            cnt_q       <= cnt_d;
            done        <= done_d;
            quotient    <= quotient_d;
            remainder   <= remainder_d;
            div_by_zero <= dz_d;
        end
    end

    assign busy = (state_q == RUN);

endmodule

// File: tb/tb_seq_unsigned_divider.sv
module tb_seq_unsigned_divider;

    logic       clk = 1'b0;
    logic       rst, en, start;
    logic [7:0] dividend, divisor;
    logic       busy, done, div_by_zero;
    logic [7:0] quotient, remainder;

    logic       en4, start4;
    logic [3:0] a4, b4;
    logic       busy4, done4, dz4;
    logic [3:0] q4, r4;

    int errors = 0;
    int checks = 0;

    // Result the 8-bit DUT should currently be holding
    logic [7:0] held_q = 8'd0, held_r = 8'd0;
    logic       held_dz = 1'b0;

    always #5 clk = ~clk;

    seq_unsigned_divider #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .en(en), .start(start),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient),
        .remainder(remainder), .div_by_zero(div_by_zero)
    );

    seq_unsigned_divider #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .en(en4), .start(start4),
        .dividend(a4), .divisor(b4),
        .busy(busy4), .done(done4), .quotient(q4),
        .remainder(r4), .div_by_zero(dz4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one 8-bit operation and follow it to done. gap: en held low for
    // that many cycles from the 4th cycle after start. poke: a junk start is
    // issued while busy.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input int gap,
                       input bit poke, input string tag);
        int         cyc, busy_cnt, exp_lat, exp_busy;
        bit         stable;
        logic [7:0] eq, er;
        logic       edz;
        if (b == 8'd0) begin
            eq = 8'hFF; er = a; edz = 1'b1; exp_lat = 1; exp_busy = 0;
        end else begin
            eq = a / b; er = a % b; edz = 1'b0; exp_lat = 9 + gap; exp_busy = 8 + gap;
        end
        en = 1'b1; start = 1'b1; dividend = a; divisor = b;
        tick();
        start = 1'b0; dividend = 8'($urandom); divisor = 8'($urandom);
        cyc = 1; busy_cnt = 0; stable = 1'b1;
        while (!done && cyc < 60) begin
            if (busy) busy_cnt++;
            if (quotient !== held_q || remainder !== held_r || div_by_zero !== held_dz)
                stable = 1'b0;
            en = !(cyc >= 4 && cyc < 4 + gap);
            if (poke && cyc == 3) begin
                start = 1'b1; dividend = 8'($urandom); divisor = 8'($urandom_range(1, 255));
            end
            tick();
            start = 1'b0;
            cyc++;
        end
        en = 1'b1;
        check({tag, "_latency"}, cyc, exp_lat);
        check({tag, "_held"}, stable, 1);
        check({tag, "_busy_cycles"}, busy_cnt, exp_busy);
        check({tag, "_busy_at_done"}, busy, 0);
        check({tag, "_quotient"}, quotient, eq);
        check({tag, "_remainder"}, remainder, er);
        check({tag, "_dz"}, div_by_zero, edz);
        held_q = eq; held_r = er; held_dz = edz;
    endtask

    initial begin
        int  cyc;
        bit  seen;
        rst = 1'b1; en = 1'b1; start = 1'b0; dividend = 8'd0; divisor = 8'd0;
        en4 = 1'b1; start4 = 1'b0; a4 = 4'd0; b4 = 4'd0;
        tick(); tick();
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dz", div_by_zero, 0);

        // Basic, divide-by-zero, boundaries (each also verifies the previous result is held)
        op8(8'd200, 8'd7, 0, 1'b0, "t1_200_7");
        en = 1'b0; tick(); tick(); tick();
        check("done_hold_en0", done, 1);
        check("done_hold_q", quotient, 28);
        en = 1'b1; tick();
        check("done_clear", done, 0);

        op8(8'd13, 8'd0, 0, 1'b0, "t2_13_0");
        op8(8'd255, 8'd1, 0, 1'b0, "t3_255_1");
        op8(8'd5, 8'd9, 0, 1'b0, "t3_5_9");
        op8(8'd0, 8'd3, 0, 1'b0, "t3_0_3");
        op8(8'd255, 8'd255, 0, 1'b0, "t3_255_255");

        // Back-to-back from the done cycle, with a start pulse while busy
        op8(8'd100, 8'd10, 0, 1'b0, "t4_100_10");
        op8(8'd77, 8'd8, 0, 1'b1, "t4_77_8");

        // Reset on the 3rd RUN cycle
        tick();
        start = 1'b1; dividend = 8'd200; divisor = 8'd7;
        tick();
        start = 1'b0;
        tick(); tick();
        check("t5_busy_before_rst", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_rst_busy", busy, 0);
        check("t5_rst_done", done, 0);
        check("t5_rst_quotient", quotient, 0);
        check("t5_rst_remainder", remainder, 0);
        check("t5_rst_dz", div_by_zero, 0);
        seen = 1'b0;
        repeat (12) begin
            tick();
            if (done || busy) seen = 1'b1;
        end
        check("t5_no_done_after_rst", seen, 0);
        held_q = 8'd0; held_r = 8'd0; held_dz = 1'b0;

        // rst and start together: start is dropped
        rst = 1'b1; start = 1'b1; dividend = 8'd13; divisor = 8'd0;
        tick();
        rst = 1'b0; start = 1'b0;
        check("rst_start_done", done, 0);
        check("rst_start_dz", div_by_zero, 0);
        tick();
        check("rst_start_busy", busy, 0);
        check("rst_start_done2", done, 0);

        // en low for 4 cycles mid-RUN
        op8(8'd200, 8'd7, 4, 1'b0, "t5_en_gap");

        // Randomized 8-bit operations
        for (int k = 0; k < 40; k++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            op8(ra, rb, (k % 3 == 0) ? int'($urandom_range(0, 3)) : 0, 1'b0, "rand8");
        end

        // Exhaustive 4-bit sweep with random enable gaps
        for (int i = 0; i < 256; i++) begin
            logic [3:0] a, b, eq, er;
            logic       edz;
            a = i[7:4]; b = i[3:0];
            if (b == 4'd0) begin
                eq = 4'hF; er = a; edz = 1'b1;
            end else begin
                eq = a / b; er = a % b; edz = 1'b0;
            end
            en4 = 1'b1; start4 = 1'b1; a4 = a; b4 = b;
            tick();
            start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
            cyc = 0;
            while (!done4 && cyc < 200) begin
                en4 = ($urandom_range(0, 3) != 0);
                tick();
                cyc++;
            end
            en4 = 1'b1;
            check("w4_done_seen", done4, 1);
            check("w4_quotient", q4, eq);
            check("w4_remainder", r4, er);
            check("w4_dz", dz4, edz);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
